// File: rtl/isp_blc_stats.sv
// Black level correction, per-channel gain with round-half-up, white clip and
// per-frame clip statistics for the raw Bayer path. Fixed 3-cycle latency.
module isp_blc_stats #(
  parameter int unsigned BITS      = 12,
  parameter int unsigned GAIN_BITS = 16,
  parameter int unsigned FRAC_BITS = 14,
  parameter int unsigned BAYER     = 0,
  parameter int unsigned CNT_BITS  = 24
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 blc_en,
  input  logic                 linear_en,
  input  logic [BITS-1:0]      black_r,
  input  logic [BITS-1:0]      black_gr,
  input  logic [BITS-1:0]      black_gb,
  input  logic [BITS-1:0]      black_b,
  input  logic [GAIN_BITS-1:0] gain_r,
  input  logic [GAIN_BITS-1:0] gain_gr,
  input  logic [GAIN_BITS-1:0] gain_gb,
  input  logic [GAIN_BITS-1:0] gain_b,
  input  logic                 in_href,
  input  logic                 in_vsync,
  input  logic [BITS-1:0]      in_raw,
  output logic                 out_href,
  output logic                 out_vsync,
  output logic [BITS-1:0]      out_raw,
  output logic [CNT_BITS-1:0]  underflow_cnt,
  output logic [CNT_BITS-1:0]  sat_cnt,
  output logic                 stats_valid
);

  localparam int unsigned PW = BITS + GAIN_BITS;
  localparam int unsigned RW = PW + 1;
  localparam logic [BITS-1:0]      PIX_MAX = '1;
  localparam logic [GAIN_BITS-1:0] UNITY   = GAIN_BITS'(1) << FRAC_BITS;
  localparam logic [RW-1:0]        HALF    = RW'(1) << (FRAC_BITS - 1);

  // Frame-shadowed configuration, indexed by CFA format (0 R, 1 Gr, 2 Gb, 3 B)
  logic                 sh_blc_en;
  logic                 sh_lin_en;
  logic [BITS-1:0]      sh_black [4];
  logic [GAIN_BITS-1:0] sh_gain  [4];

  logic vs_d, href_d, odd_pix, odd_line;
  logic vs_rise;
  logic [1:0] fmt;

  assign vs_rise = in_vsync & ~vs_d;
  assign fmt     = 2'(BAYER) ^ {odd_line, odd_pix};

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_d      <= 1'b0;
      href_d    <= 1'b0;
      odd_pix   <= 1'b0;
      odd_line  <= 1'b0;
      sh_blc_en <= 1'b0;
      sh_lin_en <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_black[i] <= '0;
        sh_gain[i]  <= UNITY;
      end
    end else begin
      vs_d    <= in_vsync;
      href_d  <= in_href;
      odd_pix <= in_href ? ~odd_pix : 1'b0;
      if (in_vsync)
        odd_line <= 1'b0;
      else if (href_d & ~in_href)
        odd_line <= ~odd_line;
      if (vs_rise) begin
        sh_blc_en   <= blc_en;
        sh_lin_en   <= linear_en;
        sh_black[0] <= black_r;
        sh_black[1] <= black_gr;
        sh_black[2] <= black_gb;
        sh_black[3] <= black_b;
        sh_gain[0]  <= gain_r;
        sh_gain[1]  <= gain_gr;
        sh_gain[2]  <= gain_gb;
        sh_gain[3]  <= gain_b;
      end
    end
  end

  // Stage 1: black subtraction with clamp at zero
  logic [BITS-1:0] blk, d_nxt;
  logic            uf_nxt;

  always_comb begin
    blk    = sh_black[fmt];
    d_nxt  = in_raw;
    uf_nxt = 1'b0;
    if (sh_blc_en) begin
      d_nxt  = (in_raw > blk) ? in_raw - blk : '0;
      uf_nxt = in_href & (in_raw < blk);
    end
  end

  logic [BITS-1:0] d1;
  logic [1:0]      fmt1;
  logic            uf1, href1, vs1;

  always_ff @(posedge pclk) begin
    if (rst) begin
      d1    <= '0;
      fmt1  <= '0;
      uf1   <= 1'b0;
      href1 <= 1'b0;
      vs1   <= 1'b0;
    end else begin
      d1    <= d_nxt;
      fmt1  <= fmt;
      uf1   <= uf_nxt;
      href1 <= in_href;
      vs1   <= in_vsync;
    end
  end

  // Stage 2: fixed-point gain, or a pure shift to keep the same scaling at unity
  logic [PW-1:0] p_nxt;

  always_comb begin
    if (sh_lin_en)
      p_nxt = PW'(d1) * PW'(sh_gain[fmt1]);
    else
      p_nxt = PW'(d1) << FRAC_BITS;
  end

  logic [PW-1:0] p2;
  logic          uf2, href2, vs2;

  always_ff @(posedge pclk) begin
    if (rst) begin
      p2    <= '0;
      uf2   <= 1'b0;
      href2 <= 1'b0;
      vs2   <= 1'b0;
    end else begin
      p2    <= p_nxt;
      uf2   <= uf1;
      href2 <= href1;
      vs2   <= vs1;
    end
  end

  // Stage 3: round half up, clip to full scale
  logic [RW-1:0]   r;
  logic            over;
  logic [BITS-1:0] clip;

  always_comb begin
    r    = (RW'(p2) + HALF) >> FRAC_BITS;
    over = r > RW'(PIX_MAX);
    clip = over ? PIX_MAX : BITS'(r);
  end

  // Flags are evaluated for the pixel entering the output register so the
  // frame report lands on the same cycle out_vsync rises.
  logic uf_hit, sat_hit, frame_edge;
  logic [CNT_BITS-1:0] run_uf, run_sat;

  assign uf_hit     = href2 & uf2;
  assign sat_hit    = href2 & over;
  assign frame_edge = vs2 & ~out_vsync;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (&c) ? c : c + CNT_BITS'(1);
  endfunction

  always_ff @(posedge pclk) begin
    if (rst) begin
      out_raw       <= '0;
      out_href      <= 1'b0;
      out_vsync     <= 1'b0;
      run_uf        <= '0;
      run_sat       <= '0;
      underflow_cnt <= '0;
      sat_cnt       <= '0;
      stats_valid   <= 1'b0;
    end else begin
      out_raw     <= href2 ? clip : '0;
      out_href    <= href2;
      out_vsync   <= vs2;
      stats_valid <= frame_edge;
      if (frame_edge) begin
        underflow_cnt <= run_uf;
        sat_cnt       <= run_sat;
        run_uf        <= CNT_BITS'(uf_hit);
        run_sat       <= CNT_BITS'(sat_hit);
      end else begin
        if (uf_hit)  run_uf  <= sat_inc(run_uf);
        if (sat_hit) run_sat <= sat_inc(run_sat);
      end
    end
  end

endmodule

// File: doc/isp_blc_stats.md
Name: isp_blc_stats

Overview:
Parametrised next-generation black level correction and linearisation stage for the raw Bayer path. It sits directly after the sensor capture interface and ahead of demosaic. Compared with the current BLC it adds a configurable gain format, round-half-up arithmetic and per-frame shadowed configuration. It also collects per-frame clip statistics (black-clamp underflow and white saturation counts) for the AE/calibration firmware.

Parameters:
BITS, 12, raw pixel width.
GAIN_BITS, 16, unsigned gain width.
FRAC_BITS, 14, fractional bits of gain (1.0 = 1<<FRAC_BITS); must be >=1 and < GAIN_BITS.
BAYER, 0, CFA phase of first pixel of frame: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.
CNT_BITS, 24, width of statistics counters.

Ports:
pclk  in  1  pixel clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
blc_en  in  1  enable black subtraction (0: pass-through to gain stage).
linear_en  in  1  enable gain multiply (0: unity gain).
black_r / black_gr / black_gb / black_b  in  BITS each  per-channel black level.
gain_r / gain_gr / gain_gb / gain_b  in  GAIN_BITS each  per-channel gain, unsigned fixed point.
in_href  in  1  line valid.
in_vsync  in  1  frame sync, active-high.
in_raw  in  BITS  raw pixel.
out_href  out  1  in_href delayed 3 cycles.
out_vsync  out  1  in_vsync delayed 3 cycles.
out_raw  out  BITS  corrected pixel; 0 when out_href low.
underflow_cnt  out  CNT_BITS  pixels clamped to 0 in previous frame.
sat_cnt  out  CNT_BITS  pixels saturated in previous frame.
stats_valid  out  1  one-cycle pulse when counts update.

Behaviour:
- Reset (rst=1 at clock edge): all pipeline regs, out_*, counts, stats_valid = 0.
  - Shadow config after reset: black_* = 0, gain_* = 1<<FRAC_BITS, blc_en = 0, linear_en = 0.
- Shadow config: all config inputs are captured into shadow registers on the cycle in_vsync rises (in_vsync=1, prior-cycle in_vsync=0). No other updates occur, so config changes mid-frame take effect from the next frame. The datapath uses only the shadow values.
- CFA phase:
  - odd_pix clears when in_href=0 and toggles each in_href=1 cycle.
  - odd_line clears while in_vsync=1 and toggles on each in_href falling edge.
  - format = BAYER ^ {odd_line, odd_pix}: 0 R, 1 Gr, 2 Gb, 3 B.
- Stage 1 (subtract):
  - If blc_en: d1 = in_raw > black ? in_raw - black : 0. uf1 = href & (in_raw < black). Equality gives 0 with no flag.
  - Else: d1 = in_raw, uf1 = 0.
  - format is registered alongside d1.
- Stage 2 (gain): p2 = d1 * gain (BITS+GAIN_BITS wide) if linear_en, else d1 << FRAC_BITS.
- Stage 3 (round/clip):
  - r = (p2 + (1<<(FRAC_BITS-1))) >> FRAC_BITS, computed with one extra bit so the add cannot overflow.
  - out = r > 2^BITS-1 ? 2^BITS-1 : r.
  - sat flag = out_href-qualified (r > 2^BITS-1). Exactly 2^BITS-1 is not flagged.
- Latency: exactly 3 pclk from in_* to out_*. Back-to-back pixels are accepted every cycle; no stall.
- out_raw is forced to 0 whenever out_href=0.
- Statistics:
  - Flags travel down the pipe aligned with the pixel. The running counters increment on out_href & flag and saturate at 2^CNT_BITS-1 (no wrap).
  - On an out_vsync rising edge: running counts are copied to underflow_cnt/sat_cnt and stats_valid=1 for that one cycle. Running counters then restart at 0, or at 1 if a flagged pixel is on the output that same cycle.
  - The first out_vsync after reset reports 0/0.
- rst asserted mid-frame: the pipe flushes, and outputs are 0 on the next cycle. Bayer phase restarts. Shadow config returns to reset defaults until the next vsync rise.

Test Plan:
- Reset: hold rst 4 cycles with in_href=1, in_raw=0xFFF -> out_raw=0, out_href=0, counts 0, stats_valid=0. After release, the first pixel appears 3 cycles after its input.
- BLC, BITS=12, RGGB: black_r=64, black_gr=32, blc_en=1, linear_en=0. Line 0 inputs 100,100 -> outputs 36,68. Line 1 first pixel (Gb, black_gb=16) input 16 -> 0, not counted as underflow.
- Gain rounding: gain_r=0x6000 (1.5), black=0, in 101 -> 152 (151.5 rounds up); in 1 -> 2 (1.5 rounds up). gain=0x4000 gives identity.
- Saturation: gain_b=0x8000 (2.0). B in 2047 -> 4094, no flag; B in 2048 -> 4095, flagged; B in 4000 -> 4095, flagged. On next vsync rise: sat_cnt=2, stats_valid pulses exactly once.
- Shadowing: change black_r 64->128 mid-frame -> R pixel 200 still outputs 136 in the current frame, and 72 after the next in_vsync rise.
- Underflow stats: frame with 3 pixels below black and 5 at or above it -> at out_vsync rise, underflow_cnt=3. Next frame with none -> 0.
